// File: rtl/mdu_defs_pkg.sv
// Shared decode constants, multiplier op codes and FSM encoding for the MDU sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mdu_defs;

  // ALUOp value that hands decode over to the funct field
  localparam logic [1:0] OP_RTYPE    = 2'b10;

  // funct field values recognised by the multiply/divide unit
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_MADDU = 6'h01;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;

  // 4-bit operation / result-select codes
  localparam logic [3:0] MULTU       = 4'b1010;
  localparam logic [3:0] MADDU       = 4'b1011;
  localparam logic [3:0] MFHI        = 4'b1001;
  localparam logic [3:0] MFLO        = 4'b1000;
  localparam logic [3:0] ADD         = 4'b0010;
  localparam logic [3:0] NONE        = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } mduState_t;

  // Everything the sequencer needs to know about the EX-stage instruction
  typedef struct packed {
    logic       isMul;    // MULTU or MADDU presented
    logic       isMf;     // MFHI or MFLO presented
    logic [3:0] mulCode;  // code to latch onto the multiplier
    logic [3:0] muxSel;   // EX result-mux select
  } decode_t;

endpackage

// File: rtl/mdu_decode.sv
// Combinational op/funct decode for the multiply unit and the EX result mux.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow the inputs every cycle.
module mdu_decode
  import mdu_defs::*;
(
  input  logic       issue_valid,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output decode_t    dec
);

  // Only a valid R-type instruction produces decode side effects; all else selects the ALU
  always_comb begin
    dec         = '0;
    dec.mulCode = NONE;
    dec.muxSel  = ADD;
    if (issue_valid && (op == OP_RTYPE)) begin
      case (funct)
        FUNCT_MULTU: begin
          dec.isMul   = 1'b1;
          dec.mulCode = MULTU;
        end
        FUNCT_MADDU: begin
          dec.isMul   = 1'b1;
          dec.mulCode = MADDU;
        end
        FUNCT_MFHI: begin
          dec.isMf    = 1'b1;
          dec.muxSel  = MFHI;
        end
        FUNCT_MFLO: begin
          dec.isMf    = 1'b1;
          dec.muxSel  = MFLO;
        end
        default: begin
          dec.muxSel  = ADD;
        end
      endcase
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Sequences multicycle MULTU/MADDU operations and the HI/LO write, stalling hazards.
// Latency: start pulse 1 cycle after accept, HI/LO write MUL_CYCLES+1 cycles after accept.
// Backpressure: stall holds a mul or MFHI/MFLO while busy; other ALU ops never stall.
module mdu_sequencer
  import mdu_defs::*;
#(
  parameter int MUL_CYCLES = 32,  // start pulse to result valid, at least 2
  parameter int CNT_W      = 6    // 2**CNT_W must exceed MUL_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       mul_start,
  output logic [3:0] mul_signal,
  output logic       hilo_we,
  output logic [3:0] mux_sel,
  output logic       busy,
  output logic       stall
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  decode_t          dec;
  mduState_t        state;
  logic [CNT_W-1:0] cnt;

  mdu_decode uDecode (
    .issue_valid (issue_valid),
    .op          (op),
    .funct       (funct),
    .dec         (dec)
  );

  // Result select follows the current EX instruction directly
  assign mux_sel = dec.muxSel;

  // Hold a new multiply or an HI/LO read while an earlier multiply is still in flight,
  // including its WRITE cycle, since HI/LO only settles at the end of WRITE
  assign stall = (dec.isMul | dec.isMf) & busy;

  // FSM: accept in IDLE, count MUL_CYCLES cycles in RUN, strobe HI/LO in WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mul_start  <= 1'b0;
      mul_signal <= NONE;
      hilo_we    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dec.isMul) begin
            state      <= RUN;
            cnt        <= CNT_LOAD;
            mul_start  <= 1'b1;
            mul_signal <= dec.mulCode;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          mul_start <= 1'b0;
          if (cnt == '0) begin
            state   <= WRITE;
            hilo_we <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        WRITE: begin
          state      <= IDLE;
          hilo_we    <= 1'b0;
          mul_signal <= NONE;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          mul_start  <= 1'b0;
          mul_signal <= NONE;
          hilo_we    <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes expected per-cycle values and pulse times.
// Latency: checks are keyed by absolute cycle number counted from posedges.
// Backpressure: stalled instructions are held presented by the stimulus until accepted.
module tb_mdu_sequencer;

  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = 6;

  localparam int S_START = 0;
  localparam int S_MSIG  = 1;
  localparam int S_WE    = 2;
  localparam int S_MUX   = 3;
  localparam int S_BUSY  = 4;
  localparam int S_STALL = 5;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mul_start;
  logic [3:0] mul_signal;
  logic       hilo_we;
  logic [3:0] mux_sel;
  logic       busy;
  logic       stall;

  exp_t expQ[$];
  int   startQ[$];
  int   weQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   b;
  logic [3:0] monAct;
  int         monExp;

  mdu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .op          (op),
    .funct       (funct),
    .mul_start   (mul_start),
    .mul_signal  (mul_signal),
    .hilo_we     (hilo_we),
    .mux_sel     (mux_sel),
    .busy        (busy),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  // Cycle N is the interval following the N-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sigName(input int s);
    case (s)
      S_START: return "mul_start";
      S_MSIG:  return "mul_signal";
      S_WE:    return "hilo_we";
      S_MUX:   return "mux_sel";
      S_BUSY:  return "busy";
      default: return "stall";
    endcase
  endfunction

  function automatic logic [3:0] sample(input int s);
    case (s)
      S_START: return {3'b000, mul_start};
      S_MSIG:  return mul_signal;
      S_WE:    return {3'b000, hilo_we};
      S_MUX:   return mux_sel;
      S_BUSY:  return {3'b000, busy};
      default: return {3'b000, stall};
    endcase
  endfunction

  task automatic expAt(input int c, input int s, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    expQ.push_back(e);
  endtask

  task automatic goTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setIn(input logic v, input logic [1:0] o, input logic [5:0] f);
    issue_valid = v;
    op          = o;
    funct       = f;
  endtask

  // Monitor: compare every due level expectation and every start/write pulse at the falling edge
  always @(negedge clk) begin
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].cyc == cyc) begin
        checks++;
        monAct = sample(expQ[i].sig);
        if (monAct !== expQ[i].val) begin
          errors++;
          $display("FAIL %s cycle %0d: got %b, expected %b",
                   sigName(expQ[i].sig), cyc, monAct, expQ[i].val);
        end
        expQ.delete(i);
      end
    end
    if (mul_start === 1'b1) begin
      checks++;
      if (startQ.size() == 0) begin
        errors++;
        $display("FAIL mul_start_pulse cycle %0d: got unexpected pulse, expected none", cyc);
      end else begin
        monExp = startQ.pop_front();
        if (monExp != cyc) begin
          errors++;
          $display("FAIL mul_start_pulse: got cycle %0d, expected cycle %0d", cyc, monExp);
        end
      end
    end
    if (hilo_we === 1'b1) begin
      checks++;
      if (weQ.size() == 0) begin
        errors++;
        $display("FAIL hilo_we_pulse cycle %0d: got unexpected pulse, expected none", cyc);
      end else begin
        monExp = weQ.pop_front();
        if (monExp != cyc) begin
          errors++;
          $display("FAIL hilo_we_pulse: got cycle %0d, expected cycle %0d", cyc, monExp);
        end
      end
    end
  end

  initial begin
    // Reset, with a MULTU presented that must be ignored while rst is high
    rst = 1'b1;
    setIn(1'b1, 2'b10, 6'h19);
    goTo(3);
    expAt(3, S_BUSY, 4'd0);
    expAt(3, S_START, 4'd0);
    expAt(3, S_MSIG, 4'b0000);
    expAt(3, S_WE, 4'd0);
    expAt(3, S_STALL, 4'd0);
    goTo(4);
    rst = 1'b0;
    setIn(1'b0, 2'b00, 6'h00);

    // 1: lone MULTU timing
    goTo(6);
    b = cyc;
    setIn(1'b1, 2'b10, 6'h19);
    startQ.push_back(b + 1);
    weQ.push_back(b + 33);
    expAt(b,      S_STALL, 4'd0);
    expAt(b + 1,  S_MSIG, 4'b1010);
    expAt(b + 2,  S_START, 4'd0);
    expAt(b + 33, S_MSIG, 4'b1010);
    expAt(b + 33, S_BUSY, 4'd1);
    expAt(b + 32, S_WE, 4'd0);
    expAt(b + 34, S_BUSY, 4'd0);
    expAt(b + 34, S_MSIG, 4'b0000);
    goTo(b + 1);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 36);

    // 2: MADDU then MFHI from cycle 5, held until it completes
    b = cyc;
    setIn(1'b1, 2'b10, 6'h01);
    startQ.push_back(b + 1);
    weQ.push_back(b + 33);
    expAt(b + 1,  S_MSIG, 4'b1011);
    expAt(b + 10, S_MSIG, 4'b1011);
    expAt(b + 4,  S_STALL, 4'd0);
    expAt(b + 5,  S_STALL, 4'd1);
    expAt(b + 5,  S_MUX, 4'b1001);
    expAt(b + 33, S_STALL, 4'd1);
    expAt(b + 34, S_STALL, 4'd0);
    expAt(b + 34, S_MUX, 4'b1001);
    goTo(b + 1);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 5);
    setIn(1'b1, 2'b10, 6'h10);
    goTo(b + 35);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 37);

    // 3: ADD overlapping a MULTU
    b = cyc;
    setIn(1'b1, 2'b10, 6'h19);
    startQ.push_back(b + 1);
    weQ.push_back(b + 33);
    expAt(b + 10, S_STALL, 4'd0);
    expAt(b + 10, S_MUX, 4'b0010);
    expAt(b + 10, S_BUSY, 4'd1);
    expAt(b + 34, S_BUSY, 4'd0);
    goTo(b + 1);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 10);
    setIn(1'b1, 2'b10, 6'h20);
    goTo(b + 11);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 36);

    // 4: back-to-back MULTU; the second is held until accepted at edge 34
    b = cyc;
    setIn(1'b1, 2'b10, 6'h19);
    startQ.push_back(b + 1);
    startQ.push_back(b + 35);
    weQ.push_back(b + 33);
    weQ.push_back(b + 67);
    expAt(b,      S_STALL, 4'd0);
    expAt(b + 1,  S_STALL, 4'd1);
    expAt(b + 33, S_STALL, 4'd1);
    expAt(b + 34, S_STALL, 4'd0);
    expAt(b + 34, S_BUSY, 4'd0);
    expAt(b + 35, S_BUSY, 4'd1);
    expAt(b + 35, S_MSIG, 4'b1010);
    goTo(b + 35);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 70);

    // 5: reset mid-RUN aborts the multiply; a fresh MULTU starts cleanly
    b = cyc;
    setIn(1'b1, 2'b10, 6'h19);
    startQ.push_back(b + 1);
    startQ.push_back(b + 23);
    weQ.push_back(b + 55);
    expAt(b + 20, S_BUSY, 4'd1);
    expAt(b + 21, S_BUSY, 4'd0);
    expAt(b + 21, S_MSIG, 4'b0000);
    expAt(b + 21, S_START, 4'd0);
    expAt(b + 21, S_WE, 4'd0);
    expAt(b + 21, S_STALL, 4'd0);
    expAt(b + 23, S_MSIG, 4'b1010);
    goTo(b + 1);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 20);
    rst = 1'b1;
    goTo(b + 21);
    rst = 1'b0;
    setIn(1'b1, 2'b10, 6'h10);
    goTo(b + 22);
    setIn(1'b1, 2'b10, 6'h19);
    goTo(b + 23);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 57);

    // 6: MFLO while idle, then a non-R-type op carrying the MULTU funct
    b = cyc;
    setIn(1'b1, 2'b10, 6'h12);
    expAt(b,     S_STALL, 4'd0);
    expAt(b,     S_MUX, 4'b1000);
    expAt(b + 1, S_MUX, 4'b0010);
    expAt(b + 1, S_STALL, 4'd0);
    expAt(b + 2, S_BUSY, 4'd0);
    expAt(b + 2, S_MUX, 4'b0010);
    expAt(b + 3, S_BUSY, 4'd0);
    expAt(b + 3, S_MUX, 4'b1001);
    goTo(b + 1);
    setIn(1'b1, 2'b00, 6'h19);
    goTo(b + 2);
    setIn(1'b0, 2'b10, 6'h19);
    goTo(b + 3);
    setIn(1'b1, 2'b10, 6'h10);
    goTo(b + 4);
    setIn(1'b0, 2'b00, 6'h00);
    goTo(b + 8);

    // Every expectation and expected pulse must have been consumed
    checks++;
    if (expQ.size() != 0 || startQ.size() != 0 || weQ.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d/%0d/%0d pending, expected 0/0/0",
               expQ.size(), startQ.size(), weQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Controls the multicycle unsigned multiplier (MULTU/MADDU) and the HI/LO register pair inside the EX-stage ALU complex. It decodes op/funct from the EX stage and issues a one-cycle start pulse with a held operation code to the multiplier. It counts the multiplier latency, generates the HI/LO write strobe, and stalls the pipeline when a multiply or an MFHI/MFLO meets an in-flight multiply.

Parameters:
MUL_CYCLES, 32, multiplier latency in cycles from the start pulse to result valid (min 2)
CNT_W, 6, width of the internal latency counter (must satisfy 2^CNT_W > MUL_CYCLES)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
issue_valid  input  1  EX-stage instruction valid this cycle
op  input  2  ALUOp from the main control; 2'b10 = R-type/funct decode
funct  input  6  instruction funct field
mul_start  output  1  one-cycle start pulse to the multiplier
mul_signal  output  4  operation code to the multiplier; held for the whole operation
hilo_we  output  1  HI/LO write strobe (one cycle)
mux_sel  output  4  result-mux select for the current EX instruction
busy  output  1  multiply in flight (state != IDLE)
stall  output  1  freeze IF/ID/EX this cycle

Behaviour:
- Decode is active only when op==2'b10:
  - funct 6'h19 -> MULTU
  - funct 6'h01 -> MADDU
  - funct 6'h10 -> MFHI
  - funct 6'h12 -> MFLO
  - anything else -> ALU op
- mux_sel is combinational from the decode: MFHI=4'b1001, MFLO=4'b1000, otherwise pass-through of the ALU code (4'b0010 default).
- FSM states:
  - IDLE: if issue_valid and is_mul -> RUN. Load cnt=MUL_CYCLES-1, register mul_start=1, latch mul_signal (MULTU=4'b1010, MADDU=4'b1011).
  - RUN: mul_start=0 after the first RUN cycle. If cnt!=0, cnt<=cnt-1. If cnt==0 -> WRITE with hilo_we<=1.
  - WRITE: hilo_we<=0, mul_signal<=4'b0000 -> IDLE.
- Timing: if a multiply is accepted at edge k, then mul_start is high in cycle k+1, RUN lasts exactly MUL_CYCLES cycles, hilo_we is high in cycle k+1+MUL_CYCLES, and busy is high from cycle k+1 through k+1+MUL_CYCLES.
- stall (combinational) = issue_valid & (is_mul | is_mf) & busy.
  - MFHI/MFLO in WRITE stalls one more cycle, because HI/LO updates at the end of WRITE.
  - A stalled instruction stays presented by the pipeline and is accepted (mul) or completes (mf) in the first IDLE cycle.
- Non-mul, non-mf instructions never stall, even while busy; ALU ops overlap the multiply.
- An IDLE-state mul accept does not stall. Back-to-back multiplies are therefore spaced MUL_CYCLES+2 cycles apart.
- issue_valid low or op!=2'b10: no decode side effects. mux_sel defaults to the ALU code.
- Reset: rst sampled high at any edge, including mid-RUN or WRITE:
  - state=IDLE, cnt=0
  - mul_start=0, mul_signal=4'b0000, hilo_we=0
  - busy=0, hence stall=0
  - The aborted multiply is not resumed and HI/LO is not written.
- All outputs are registered except stall and mux_sel.

Decomposition:
- Shared package/include mdu_defs: funct constants (FUNCT_MULTU, FUNCT_MADDU, FUNCT_MFHI, FUNCT_MFLO), the 4-bit signal codes (MULTU, MADDU, MFHI, MFLO, ADD), and the FSM state encoding (IDLE, RUN, WRITE as a 2-bit enum).
- One natural sub-module: mdu_decode. It is combinational: op/funct -> is_mul, is_mf, mul code, mux_sel. The FSM and counter stay in mdu_sequencer.

Test Plan:
1. Reset, then issue MULTU (op=2'b10, funct=6'h19) at edge 0 with MUL_CYCLES=32 -> mul_start=1 only in cycle 1; mul_signal=4'b1010 in cycles 1..33; hilo_we=1 only in cycle 33; busy low again in cycle 34.
2. MADDU at edge 0, then MFHI presented from cycle 5 -> stall=1 in cycles 5..33; stall=0 in cycle 34 with mux_sel=4'b1001; mul_signal=4'b1011 during RUN.
3. MULTU at edge 0, then ADD (funct 6'h20) presented during cycle 10 -> stall=0, mux_sel=4'b0010, and multiply timing unchanged (hilo_we still in cycle 33).
4. Two MULTU instructions presented back-to-back -> second stalled cycles 1..33 and accepted at edge 34; second mul_start in cycle 35; second hilo_we in cycle 67.
5. rst asserted at edge 20 during RUN -> from cycle 21 all outputs 0 and busy=0; no hilo_we ever pulses for the aborted op; a new MULTU at edge 22 gives mul_start in cycle 23.
6. MFLO (funct 6'h12) while IDLE, and op=2'b00 with funct=6'h19 -> MFLO: stall=0, mux_sel=4'b1000; op=2'b00 case: no mul_start, FSM stays IDLE.
